// File: rtl/scsi_byte_packer_if.sv
// Byte/longword bus bundle between the SCSI controller data port, the packer and the DMA FIFO.
// The packer takes the master view; the SCSI controller and FIFO side take the slave view.
interface scsi_byte_packer_if;
    logic [7:0]  s_rx_data;
    logic        s_rx_vld;
    logic        s_rx_rdy;
    logic [7:0]  s_tx_data;
    logic        s_tx_vld;
    logic        s_tx_rdy;
    logic [31:0] f_wdata;
    logic [3:0]  f_wmask;
    logic        f_wr;
    logic        f_full;
    logic [31:0] f_rdata;
    logic        f_rd;
    logic        f_empty;

    modport master (
        input  s_rx_data, s_rx_vld, s_tx_rdy, f_full, f_rdata, f_empty,
        output s_rx_rdy, s_tx_data, s_tx_vld, f_wdata, f_wmask, f_wr, f_rd
    );

    modport slave (
        output s_rx_data, s_rx_vld, s_tx_rdy, f_full, f_rdata, f_empty,
        input  s_rx_rdy, s_tx_data, s_tx_vld, f_wdata, f_wmask, f_wr, f_rd
    );
endinterface

// File: rtl/scsi_byte_packer.sv
// Byte-lane engine between the 8-bit SCSI data port and the 32-bit DMA FIFO: packs bytes
// big-endian into longwords (dir=1) or unpacks longwords into bytes (dir=0), with flush.
module scsi_byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      dir,
    input  logic                      flush,
    scsi_byte_packer_if.master        bus,
    output logic [1:0]                bo,
    output logic                      busy,
    output logic                      flush_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PACK   = 3'd1,
        WRITE  = 3'd2,
        FETCH  = 3'd3,
        LOAD   = 3'd4,
        UNPACK = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  bo_r, bo_s;
    logic [31:0] pack_r, pack_s;
    logic [31:0] unpk_r, unpk_s;
    logic [3:0]  wmask_r, wmask_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        pend_r, pend_s;
    logic        done_r, done_s;
    logic        rx_rdy_r, tx_vld_r, busy_r;
    logic        wr_s, rd_s;
    logic        rx_hs_s, tx_hs_s;
    logic [2:0]  fill_s;
    logic [31:0] word_s;

    // Lane 0 is the most significant byte.
    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] l);
        case (l)
            2'd0:    get_lane = w[31:24];
            2'd1:    get_lane = w[23:16];
            2'd2:    get_lane = w[15:8];
            2'd3:    get_lane = w[7:0];
            default: get_lane = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] l,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (l)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] fill);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            r = (i >= int'(fill)) ? set_lane(r, 2'(i), PAD_BYTE) : r;
        end
        return r;
    endfunction

    function automatic logic [3:0] fill_mask(input logic [2:0] fill);
        case (fill)
            3'd1:    fill_mask = 4'b1000;
            3'd2:    fill_mask = 4'b1100;
            3'd3:    fill_mask = 4'b1110;
            3'd4:    fill_mask = 4'b1111;
            default: fill_mask = 4'b0000;
        endcase
    endfunction

    // Next-state, datapath and strobe decode; EN low overrides every state.
    always_comb begin
        state_s   = state_r;
        bo_s      = bo_r;
        pack_s    = pack_r;
        unpk_s    = unpk_r;
        wmask_s   = wmask_r;
        tx_data_s = tx_data_r;
        pend_s    = pend_r;
        done_s    = 1'b0;
        wr_s      = 1'b0;
        rd_s      = 1'b0;
        rx_hs_s   = bus.s_rx_vld & rx_rdy_r;
        tx_hs_s   = tx_vld_r & bus.s_tx_rdy;
        fill_s    = {1'b0, bo_r};
        word_s    = pack_r;
        if (!en) begin
            state_s = IDLE;
            bo_s    = 2'd0;
            pack_s  = 32'd0;
            wmask_s = 4'd0;
            pend_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bo_s = 2'd0;
                    if (flush) begin
                        done_s = 1'b1;
                    end else if (dir) begin
                        state_s = PACK;
                    end else begin
                        state_s = FETCH;
                    end
                end
                PACK: begin
                    // A byte arriving with FLUSH is stored before the flush is evaluated.
                    if (rx_hs_s) begin
                        word_s = set_lane(pack_r, bo_r, bus.s_rx_data);
                        fill_s = {1'b0, bo_r} + 3'd1;
                    end else begin
                        word_s = pack_r;
                        fill_s = {1'b0, bo_r};
                    end
                    pack_s = word_s;
                    if (fill_s == 3'd4) begin
                        state_s = WRITE;
                        wmask_s = 4'b1111;
                        bo_s    = 2'd0;
                        pend_s  = flush;
                    end else if (flush) begin
                        if (fill_s == 3'd0) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            pack_s  = pad_word(word_s, fill_s);
                            wmask_s = fill_mask(fill_s);
                            state_s = WRITE;
                            bo_s    = 2'd0;
                            pend_s  = 1'b1;
                        end
                    end else begin
                        bo_s = fill_s[1:0];
                    end
                end
                WRITE: begin
                    wr_s   = ~bus.f_full;
                    pend_s = pend_r | flush;
                    if (!bus.f_full) begin
                        pend_s = 1'b0;
                        if (pend_r | flush) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = PACK;
                        end
                    end else begin
                        state_s = WRITE;
                    end
                end
                FETCH: begin
                    // No read is issued alongside FLUSH so no FIFO word is lost.
                    if (flush) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else if (!bus.f_empty) begin
                        rd_s    = 1'b1;
                        state_s = LOAD;
                    end else begin
                        state_s = FETCH;
                    end
                end
                LOAD: begin
                    if (flush) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        unpk_s    = bus.f_rdata;
                        tx_data_s = bus.f_rdata[31:24];
                        bo_s      = 2'd0;
                        state_s   = UNPACK;
                    end
                end
                UNPACK: begin
                    if (flush) begin
                        state_s = IDLE;
                        bo_s    = 2'd0;
                        done_s  = 1'b1;
                    end else if (tx_hs_s) begin
                        if (bo_r == 2'd3) begin
                            state_s = FETCH;
                            bo_s    = 2'd0;
                        end else begin
                            bo_s      = bo_r + 2'd1;
                            tx_data_s = get_lane(unpk_r, bo_r + 2'd1);
                        end
                    end else begin
                        state_s = UNPACK;
                    end
                end
                default: begin
                    state_s = IDLE;
                    bo_s    = 2'd0;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bo_r      <= 2'd0;
            pack_r    <= 32'd0;
            unpk_r    <= 32'd0;
            wmask_r   <= 4'd0;
            tx_data_r <= 8'd0;
            pend_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_rdy_r  <= 1'b0;
            tx_vld_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bo_r      <= bo_s;
            pack_r    <= pack_s;
            unpk_r    <= unpk_s;
            wmask_r   <= wmask_s;
            tx_data_r <= tx_data_s;
            pend_r    <= pend_s;
            done_r    <= done_s;
            rx_rdy_r  <= (state_s == PACK);
            tx_vld_r  <= (state_s == UNPACK);
            busy_r    <= (state_s != IDLE);
        end
    end

    // FIFO strobes follow F_FULL/F_EMPTY in the same cycle so a full FIFO is never written.
    assign bus.f_wr      = wr_s;
    assign bus.f_rd      = rd_s;
    assign bus.s_rx_rdy  = rx_rdy_r;
    assign bus.s_tx_vld  = tx_vld_r;
    assign bus.s_tx_data = tx_data_r;
    assign bus.f_wdata   = pack_r;
    assign bus.f_wmask   = wmask_r;
    assign bo            = bo_r;
    assign busy          = busy_r;
    assign flush_done    = done_r;

endmodule

// File: tb/tb_scsi_byte_packer.sv
// Self-checking bench for scsi_byte_packer: directed scenarios with literal expectations plus
// randomized traffic scored against a queue-based model of bytes, longwords and flushes.
module tb_scsi_byte_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en, dir, flush;
    logic [1:0] bo;
    logic       busy, flush_done;

    scsi_byte_packer_if bus();

    scsi_byte_packer #(.PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .flush(flush),
        .bus(bus), .bo(bo), .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int bytes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: bytes of the word being packed, words owed to the FIFO, bytes owed to SCSI.
    logic [7:0]  part_q[$];
    logic [35:0] wq[$];
    logic [7:0]  txq[$];
    logic        flush_after = 1'b0, done_exp = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0;
    logic        hold_prev = 1'b0, dn_next;
    logic [7:0]  hold_data = 8'd0;
    logic [35:0] wtmp;

    function automatic logic [35:0] model_word();
        logic [31:0] d;
        logic [3:0]  m;
        d = 32'd0;
        m = 4'd0;
        for (int i = 0; i < 4; i++) begin
            d = d << 8;
            if (i < part_q.size()) begin
                d[7:0]  = part_q[i];
                m[3-i]  = 1'b1;
            end
        end
        return {m, d};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            part_q.delete(); wq.delete(); txq.delete();
            flush_after = 1'b0; done_exp = 1'b0; rd_prev = 1'b0; wr_prev = 1'b0;
            hold_prev = 1'b0;
        end else begin
            dn_next = 1'b0;
            chk("wr_rd_exclusive", {31'd0, bus.f_wr & bus.f_rd}, 32'd0);
            chk("strobe_back_to_back", {31'd0, (bus.f_wr & wr_prev) | (bus.f_rd & rd_prev)}, 32'd0);
            chk("f_wr_when_owed", {31'd0, bus.f_wr}, {31'd0, wq.size() > 0 && en && !bus.f_full});
            chk("flush_done", {31'd0, flush_done}, {31'd0, done_exp});
            if (wq.size() > 0) chk("rx_rdy_while_writing", {31'd0, bus.s_rx_rdy}, 32'd0);
            if (bus.s_rx_rdy) chk("bo_pack", {30'd0, bo}, part_q.size());
            if (bus.f_wr && wq.size() > 0) begin
                wtmp = wq.pop_front();
                chk("f_wdata", bus.f_wdata, wtmp[31:0]);
                chk("f_wmask", {28'd0, bus.f_wmask}, {28'd0, wtmp[35:32]});
                words_seen++;
                if (flush_after) begin
                    dn_next = 1'b1;
                    flush_after = 1'b0;
                end
            end
            if (bus.s_rx_vld && bus.s_rx_rdy) begin
                part_q.push_back(bus.s_rx_data);
                if (part_q.size() == 4) begin
                    wq.push_back(model_word());
                    part_q.delete();
                end
            end
            if (hold_prev) begin
                chk("tx_hold_vld", {31'd0, bus.s_tx_vld}, 32'd1);
                chk("tx_hold_data", {24'd0, bus.s_tx_data}, {24'd0, hold_data});
            end
            if (bus.s_tx_vld) begin
                chk("tx_vld_owed", {31'd0, txq.size() > 0}, 32'd1);
                if (txq.size() > 0) chk("bo_unpack", {30'd0, bo}, 4 - txq.size());
            end
            if (bus.s_tx_vld && bus.s_tx_rdy && txq.size() > 0) begin
                chk("s_tx_data", {24'd0, bus.s_tx_data}, {24'd0, txq.pop_front()});
                bytes_seen++;
            end
            if (bus.f_rd) chk("f_rd_when_drained", {31'd0, txq.size() == 0 && !rd_prev}, 32'd1);
            if (rd_prev && en && !flush) begin
                for (int i = 3; i >= 0; i--) txq.push_back(bus.f_rdata[i*8 +: 8]);
            end
            if (en && flush) begin
                if (wq.size() > 0) begin
                    flush_after = 1'b1;
                end else if (part_q.size() > 0) begin
                    wq.push_back(model_word());
                    part_q.delete();
                    flush_after = 1'b1;
                end else begin
                    dn_next = 1'b1;
                end
                txq.delete();
            end
            if (!en) begin
                part_q.delete(); wq.delete(); txq.delete();
                flush_after = 1'b0;
                dn_next = 1'b0;
            end
            hold_prev = bus.s_tx_vld && !bus.s_tx_rdy && en && !flush;
            hold_data = bus.s_tx_data;
            wr_prev   = bus.f_wr;
            rd_prev   = bus.f_rd;
            done_exp  = dn_next;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.s_rx_data = b;
        bus.s_rx_vld  = 1'b1;
        @(negedge clk);
        while (!bus.s_rx_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_accept_timeout", 32'd0, 32'd1);
        step();
        bus.s_rx_vld = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        chk({name, "_wr"}, {31'd0, bus.f_wr}, 32'd1);
        chk({name, "_data"}, bus.f_wdata, d);
        chk({name, "_mask"}, {28'd0, bus.f_wmask}, {28'd0, m});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[4];
        int  n;
        logic seen;
        en = 1'b0; dir = 1'b1; flush = 1'b0;
        bus.s_rx_data = 8'd0; bus.s_rx_vld = 1'b0; bus.s_tx_rdy = 1'b0;
        bus.f_full = 1'b0; bus.f_rdata = 32'd0; bus.f_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bo", {30'd0, bo}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobes", {26'd0, bus.s_rx_rdy, bus.s_tx_vld, bus.f_wr, bus.f_rd, flush_done, 1'b0}, 32'd0);
        chk("rst_data", {bus.f_wdata ^ 32'd0} | {20'd0, bus.f_wmask, bus.s_tx_data}, 32'd0);
        step();
        rst_n = 1'b1;

        // Four bytes back-to-back: one write the cycle after the fourth byte.
        en = 1'b1; dir = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        chk("pack4_wr", {31'd0, bus.f_wr}, 32'd1);
        chk("pack4_data", bus.f_wdata, 32'h11223344);
        chk("pack4_mask", {28'd0, bus.f_wmask}, 32'hF);
        chk("pack4_bo", {30'd0, bo}, 32'd0);
        step();
        @(negedge clk);
        chk("pack4_wr_single", {31'd0, bus.f_wr}, 32'd0);
        step();

        // Partial word flush.
        send_byte(8'hAA); send_byte(8'hBB);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_write("flush2", 32'hAABB0000, 4'b1100);
        @(negedge clk);
        chk("flush2_done", {31'd0, flush_done}, 32'd1);
        chk("flush2_idle", {31'd0, busy}, 32'd0);
        step();

        // FIFO full holds the write.
        bus.f_full = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_no_wr", {31'd0, bus.f_wr}, 32'd0);
            chk("full_no_rdy", {31'd0, bus.s_rx_rdy}, 32'd0);
            chk("full_data_stable", bus.f_wdata, 32'h01020304);
            step();
        end
        bus.f_full = 1'b0;
        expect_write("full_release", 32'h01020304, 4'hF);

        // Abort mid-pack, then a fresh word starting at lane 0.
        send_byte(8'h55);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_wr", {31'd0, bus.f_wr}, 32'd0);
            chk("abort_no_done", {31'd0, flush_done}, 32'd0);
            step();
        end
        @(negedge clk);
        chk("abort_idle", {29'd0, busy, bo}, 32'd0);
        step();
        en = 1'b1;
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
        expect_write("after_abort", 32'h66778899, 4'hF);

        // Unpack DEADBEEF with a toggling SCSI ready.
        en = 1'b0;
        step(); step();
        dir = 1'b0; bus.f_rdata = 32'hDEADBEEF; bus.f_empty = 1'b0; bus.s_tx_rdy = 1'b0;
        en = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (bus.s_tx_vld && bus.s_tx_rdy) begin
                got[n] = bus.s_tx_data;
                n++;
            end
            step();
            bus.s_tx_rdy = ~bus.s_tx_rdy;
        end
        bus.s_tx_rdy = 1'b0;
        chk("unpack_count", n, 32'd4);
        chk("unpack_bytes", {got[0], got[1], got[2], got[3]}, 32'hDEADBEEF);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.f_rd;
            step();
        end
        chk("refetch_rd", {31'd0, seen}, 32'd1);

        // Asynchronous reset in UNPACK.
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.s_tx_vld;
            if (!seen) step();
        end
        chk("unpack_reached", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", {26'd0, bus.s_rx_rdy, bus.s_tx_vld, bus.f_wr, bus.f_rd, flush_done, busy}, 32'd0);
        chk("arst_data", {20'd0, bus.f_wmask, bus.s_tx_data}, 32'd0);
        chk("arst_wdata", bus.f_wdata, 32'd0);
        chk("arst_bo", {30'd0, bo}, 32'd0);
        en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_idle", {29'd0, busy, bo}, 32'd0);
        step();

        // Randomized traffic, SCSI to FIFO then FIFO to SCSI.
        for (int ph = 0; ph < 2; ph++) begin
            en = 1'b0;
            dir = (ph == 0);
            step(); step();
            for (int c = 0; c < 1500; c++) begin
                en            = ($urandom_range(0, 63) != 0);
                flush         = ($urandom_range(0, 23) == 0);
                bus.s_rx_vld  = ($urandom_range(0, 3) != 0);
                bus.s_rx_data = 8'($urandom);
                bus.f_full    = ($urandom_range(0, 2) == 0);
                bus.f_empty   = ($urandom_range(0, 2) == 0);
                bus.f_rdata   = $urandom;
                bus.s_tx_rdy  = ($urandom_range(0, 1) == 1);
                step();
            end
            flush = 1'b0;
            bus.s_rx_vld = 1'b0;
        end
        en = 1'b0;
        step(); step();
        chk("random_words_progress", {31'd0, words_seen > 10}, 32'd1);
        chk("random_bytes_progress", {31'd0, bytes_seen > 10}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
